// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage MIPS pipeline.
//   Computes logic/shift/arith/move results with one cycle of latency. The EX/MEM latch
//   lives here. Owns HI/LO. Runs a restoring divider that stalls upstream while busy.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   aluop_input, alusel_input  operation code and operation class from ID/EX
//   regOp1, regOp2             operands (shifts: amount in regOp1[4:0], value in regOp2)
//   dest_addr, write_or_not    GPR destination and write enable
//   wdata_output, dest_addr_output, write_or_not_output  registered result to MEM
//   hi_output, lo_output       current HI/LO registers
//   stall_req                  combinational stall request to PC/IF/ID and ID/EX
module ex_stage #(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_input,
    input  logic [2:0]  alusel_input,
    input  logic [31:0] regOp1,
    input  logic [31:0] regOp2,
    input  logic [4:0]  dest_addr,
    input  logic        write_or_not,
    output logic [31:0] wdata_output,
    output logic [4:0]  dest_addr_output,
    output logic        write_or_not_output,
    output logic [31:0] hi_output,
    output logic [31:0] lo_output,
    output logic        stall_req
);

    localparam logic [2:0] SEL_LOGIC = 3'd1, SEL_SHIFT = 3'd2, SEL_ARITH = 3'd3,
                           SEL_MOVE = 3'd4, SEL_MULDIV = 3'd5;

    localparam logic [7:0] OP_AND = 8'h24, OP_OR = 8'h25, OP_XOR = 8'h26, OP_NOR = 8'h27,
                           OP_SLL = 8'h7C, OP_SRL = 8'h02, OP_SRA = 8'h03,
                           OP_ADDU = 8'h21, OP_SUBU = 8'h23, OP_SLT = 8'h2A, OP_SLTU = 8'h2B,
                           OP_MFHI = 8'h10, OP_MTHI = 8'h11, OP_MFLO = 8'h12, OP_MTLO = 8'h13,
                           OP_MULT = 8'h18, OP_MULTU = 8'h19, OP_DIV = 8'h1A, OP_DIVU = 8'h1B;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} div_state_e;

    div_state_e  r_state;
    logic [31:0] r_hi, r_lo;
    logic [31:0] r_quot, r_rem, r_divisor;
    logic        r_neg_q, r_neg_r;
    logic [5:0]  r_cnt;

    logic [31:0] w_result;
    logic [63:0] w_prod_s, w_prod_u;
    logic        w_is_div, w_is_signed_div, w_no_wb;
    logic        w_op1_neg, w_op2_neg;
    logic [31:0] w_abs1, w_abs2;
    logic [32:0] w_trial, w_diff;
    logic [31:0] w_q_final, w_r_final;

    assign w_prod_s = $signed({{32{regOp1[31]}}, regOp1}) * $signed({{32{regOp2[31]}}, regOp2});
    assign w_prod_u = {32'd0, regOp1} * {32'd0, regOp2};

    assign w_is_div        = (alusel_input == SEL_MULDIV) &&
                             (aluop_input == OP_DIV || aluop_input == OP_DIVU);
    assign w_is_signed_div = (aluop_input == OP_DIV);
    // These ops only touch HI/LO, so they never write a GPR.
    assign w_no_wb = (aluop_input == OP_DIV)  || (aluop_input == OP_DIVU) ||
                     (aluop_input == OP_MULT) || (aluop_input == OP_MULTU) ||
                     (aluop_input == OP_MTHI) || (aluop_input == OP_MTLO);

    // Reset wins over everything, including the cycle a divide is first presented.
    assign stall_req = !rst && ((r_state == StIdle && w_is_div) || r_state == StBusy);

    assign w_op1_neg = w_is_signed_div && regOp1[31];
    assign w_op2_neg = w_is_signed_div && regOp2[31];
    assign w_abs1    = w_op1_neg ? (~regOp1 + 32'd1) : regOp1;
    assign w_abs2    = w_op2_neg ? (~regOp2 + 32'd1) : regOp2;

    // Restoring step: shift next dividend bit into the partial remainder, subtract if it fits.
    // A clear borrow bit means the trial value was >= divisor.
    assign w_trial = {r_rem, r_quot[31]};
    assign w_diff  = w_trial - {1'b0, r_divisor};

    assign w_q_final = r_neg_q ? (~r_quot + 32'd1) : r_quot;
    assign w_r_final = r_neg_r ? (~r_rem + 32'd1) : r_rem;

    always_comb begin
        w_result = 32'd0;
        case (alusel_input)
            SEL_LOGIC: begin
                case (aluop_input)
                    OP_AND:  w_result = regOp1 & regOp2;
                    OP_OR:   w_result = regOp1 | regOp2;
                    OP_XOR:  w_result = regOp1 ^ regOp2;
                    OP_NOR:  w_result = ~(regOp1 | regOp2);
                    default: w_result = 32'd0;
                endcase
            end
            SEL_SHIFT: begin
                case (aluop_input)
                    OP_SLL:  w_result = regOp2 << regOp1[4:0];
                    OP_SRL:  w_result = regOp2 >> regOp1[4:0];
                    OP_SRA:  w_result = $signed(regOp2) >>> regOp1[4:0];
                    default: w_result = 32'd0;
                endcase
            end
            SEL_ARITH: begin
                case (aluop_input)
                    OP_ADDU: w_result = regOp1 + regOp2;
                    OP_SUBU: w_result = regOp1 - regOp2;
                    OP_SLT:  w_result = {31'd0, $signed(regOp1) < $signed(regOp2)};
                    OP_SLTU: w_result = {31'd0, regOp1 < regOp2};
                    default: w_result = 32'd0;
                endcase
            end
            SEL_MOVE: begin
                case (aluop_input)
                    OP_MFHI: w_result = r_hi;
                    OP_MFLO: w_result = r_lo;
                    default: w_result = 32'd0;
                endcase
            end
            default: w_result = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdata_output        <= 32'd0;
            dest_addr_output    <= 5'd0;
            write_or_not_output <= 1'b0;
            r_hi                <= 32'd0;
            r_lo                <= 32'd0;
            r_state             <= StIdle;
            r_quot              <= 32'd0;
            r_rem               <= 32'd0;
            r_divisor           <= 32'd0;
            r_neg_q             <= 1'b0;
            r_neg_r             <= 1'b0;
            r_cnt               <= 6'd0;
        end else begin
            wdata_output        <= w_result;
            dest_addr_output    <= dest_addr;
            write_or_not_output <= write_or_not && !stall_req && !w_no_wb;

            if (alusel_input == SEL_MULDIV && aluop_input == OP_MULT) begin
                {r_hi, r_lo} <= w_prod_s;
            end else if (alusel_input == SEL_MULDIV && aluop_input == OP_MULTU) begin
                {r_hi, r_lo} <= w_prod_u;
            end else if (alusel_input == SEL_MOVE && aluop_input == OP_MTHI) begin
                r_hi <= regOp1;
            end else if (alusel_input == SEL_MOVE && aluop_input == OP_MTLO) begin
                r_lo <= regOp1;
            end

            case (r_state)
                StIdle: begin
                    if (w_is_div) begin
                        if (regOp2 == 32'd0) begin
                            r_quot  <= 32'hFFFF_FFFF;
                            r_rem   <= regOp1;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                            r_state <= StDone;
                        end else begin
                            r_quot    <= w_abs1;
                            r_rem     <= 32'd0;
                            r_divisor <= w_abs2;
                            r_neg_q   <= w_op1_neg ^ w_op2_neg;
                            r_neg_r   <= w_op1_neg;
                            r_cnt     <= 6'd0;
                            r_state   <= StBusy;
                        end
                    end
                end
                StBusy: begin
                    if (!w_diff[32]) begin
                        r_rem  <= w_diff[31:0];
                        r_quot <= {r_quot[30:0], 1'b1};
                    end else begin
                        r_rem  <= w_trial[31:0];
                        r_quot <= {r_quot[30:0], 1'b0};
                    end
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'(DIV_CYCLES - 1)) begin
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    // The divide is still presented here; returning to idle without looking
                    // at the inputs keeps it from restarting.
                    r_hi    <= w_r_final;
                    r_lo    <= w_q_final;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign hi_output = r_hi;
    assign lo_output = r_lo;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed bench for ex_stage. A table of single-cycle vectors followed by
// hand-written divider, divide-by-zero and reset-abort sequences.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop_input;
    logic [2:0]  alusel_input;
    logic [31:0] regOp1, regOp2;
    logic [4:0]  dest_addr;
    logic        write_or_not;
    logic [31:0] wdata_output;
    logic [4:0]  dest_addr_output;
    logic        write_or_not_output;
    logic [31:0] hi_output, lo_output;
    logic        stall_req;

    int errors = 0;
    int checks = 0;

    ex_stage #(.DIV_CYCLES(32)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .aluop_input         (aluop_input),
        .alusel_input        (alusel_input),
        .regOp1              (regOp1),
        .regOp2              (regOp2),
        .dest_addr           (dest_addr),
        .write_or_not        (write_or_not),
        .wdata_output        (wdata_output),
        .dest_addr_output    (dest_addr_output),
        .write_or_not_output (write_or_not_output),
        .hi_output           (hi_output),
        .lo_output           (lo_output),
        .stall_req           (stall_req)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] NOP = 3'd0, LOG = 3'd1, SHF = 3'd2, ARI = 3'd3, MOV = 3'd4, MD = 3'd5;

    typedef struct {
        logic [2:0]  sel;
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dest;
        logic        we;
        logic [31:0] exp_wdata;
        logic        exp_we;
        logic        chk_hilo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(input logic [2:0] sel, input logic [7:0] op,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] dest, input logic we,
                                input logic [31:0] exp_wdata, input logic exp_we,
                                input logic chk_hilo, input logic [31:0] exp_hi,
                                input logic [31:0] exp_lo);
        vec_t v;
        v.sel = sel; v.op = op; v.a = a; v.b = b; v.dest = dest; v.we = we;
        v.exp_wdata = exp_wdata; v.exp_we = exp_we;
        v.chk_hilo = chk_hilo; v.exp_hi = exp_hi; v.exp_lo = exp_lo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] dest, input logic we);
        alusel_input = sel; aluop_input = op; regOp1 = a; regOp2 = b;
        dest_addr = dest; write_or_not = we;
    endtask

    // Present a divide and hold it until stall drops (as the frozen ID/EX would), then
    // through the DONE edge; check stall length, bubbles, and HI/LO timing.
    task automatic run_div(input string name, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int exp_stall,
                           input logic [31:0] prev_hi, input logic [31:0] prev_lo,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cnt = 0;
        int bad_we = 0;
        drive(MD, op, a, b, 5'd9, 1'b1);
        #1;
        while (stall_req === 1'b1 && cnt < 100) begin
            cnt++;
            tick;
            if (write_or_not_output !== 1'b0) bad_we++;
        end
        chk({name, "_stall_cycles"}, 32'(cnt), 32'(exp_stall));
        chk({name, "_bubble_we"}, 32'(bad_we), 32'd0);
        chk({name, "_hi_hold"}, hi_output, prev_hi);
        chk({name, "_lo_hold"}, lo_output, prev_lo);
        tick;
        chk({name, "_hi"}, hi_output, exp_hi);
        chk({name, "_lo"}, lo_output, exp_lo);
        chk({name, "_we"}, 32'(write_or_not_output), 32'd0);
        drive(NOP, 8'h00, 32'd0, 32'd0, 5'd0, 1'b0);
        #1;
        chk({name, "_no_restart"}, 32'(stall_req), 32'd0);
    endtask

    initial begin
        vecs[0]  = mk(ARI, 8'h21, 32'hFFFF_FFFF, 32'd2, 5'd3, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 0, 0);
        vecs[1]  = mk(ARI, 8'h23, 32'd0, 32'd1, 5'd4, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, 0);
        vecs[2]  = mk(ARI, 8'h2A, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1, 32'd1, 1'b1, 1'b0, 0, 0);
        vecs[3]  = mk(ARI, 8'h2B, 32'hFFFF_FFFF, 32'd1, 5'd6, 1'b1, 32'd0, 1'b1, 1'b0, 0, 0);
        vecs[4]  = mk(SHF, 8'h03, 32'd4, 32'h8000_0000, 5'd7, 1'b1, 32'hF800_0000, 1'b1, 1'b0, 0, 0);
        vecs[5]  = mk(LOG, 8'h27, 32'd0, 32'd0, 5'd8, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, 0);
        vecs[6]  = mk(LOG, 8'h24, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd9, 1'b0, 32'hF000_F000, 1'b0,
                      1'b0, 0, 0);
        vecs[7]  = mk(LOG, 8'h26, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd10, 1'b1, 32'h0FF0_0FF0, 1'b1,
                      1'b0, 0, 0);
        vecs[8]  = mk(LOG, 8'h25, 32'h0000_000F, 32'h0000_00F0, 5'd11, 1'b1, 32'h0000_00FF, 1'b1,
                      1'b0, 0, 0);
        vecs[9]  = mk(SHF, 8'h7C, 32'd8, 32'h0000_0012, 5'd12, 1'b1, 32'h0000_1200, 1'b1, 1'b0, 0, 0);
        vecs[10] = mk(SHF, 8'h02, 32'd4, 32'h8000_0000, 5'd13, 1'b1, 32'h0800_0000, 1'b1, 1'b0, 0, 0);
        vecs[11] = mk(LOG, 8'h99, 32'h1234_5678, 32'h1, 5'd14, 1'b1, 32'd0, 1'b1, 1'b0, 0, 0);
        vecs[12] = mk(MOV, 8'h11, 32'h0000_1234, 32'd0, 5'd15, 1'b1, 32'd0, 1'b0,
                      1'b1, 32'h0000_1234, 32'd0);
        vecs[13] = mk(MOV, 8'h10, 32'd0, 32'd0, 5'd16, 1'b1, 32'h0000_1234, 1'b1, 1'b0, 0, 0);
        vecs[14] = mk(MD, 8'h18, 32'hFFFF_FFFE, 32'd3, 5'd17, 1'b1, 32'd0, 1'b0,
                      1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        vecs[15] = mk(MD, 8'h19, 32'hFFFF_FFFF, 32'd2, 5'd18, 1'b1, 32'd0, 1'b0,
                      1'b1, 32'h0000_0001, 32'hFFFF_FFFE);
        vecs[16] = mk(MOV, 8'h12, 32'd0, 32'd0, 5'd19, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, 0, 0);
        vecs[17] = mk(MOV, 8'h13, 32'h0000_ABCD, 32'd0, 5'd20, 1'b1, 32'd0, 1'b0,
                      1'b1, 32'h0000_0001, 32'h0000_ABCD);
        vecs[18] = mk(NOP, 8'h21, 32'd5, 32'd6, 5'd21, 1'b1, 32'd0, 1'b1, 1'b0, 0, 0);

        // Reset with a nonzero divide presented: stall must stay low, everything clears.
        rst = 1'b1;
        drive(MD, 8'h1A, $urandom, $urandom | 32'd1, 5'($urandom), 1'b1);
        #1;
        chk("rst_stall_comb", 32'(stall_req), 32'd0);
        tick;
        tick;
        chk("rst_wdata", wdata_output, 32'd0);
        chk("rst_dest", 32'(dest_addr_output), 32'd0);
        chk("rst_we", 32'(write_or_not_output), 32'd0);
        chk("rst_hi", hi_output, 32'd0);
        chk("rst_lo", lo_output, 32'd0);
        chk("rst_stall", 32'(stall_req), 32'd0);

        rst = 1'b0;
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].sel, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dest, vecs[i].we);
            tick;
            chk($sformatf("vec%0d_wdata", i), wdata_output, vecs[i].exp_wdata);
            chk($sformatf("vec%0d_dest", i), 32'(dest_addr_output), 32'(vecs[i].dest));
            chk($sformatf("vec%0d_we", i), 32'(write_or_not_output), 32'(vecs[i].exp_we));
            chk($sformatf("vec%0d_stall", i), 32'(stall_req), 32'd0);
            if (vecs[i].chk_hilo) begin
                chk($sformatf("vec%0d_hi", i), hi_output, vecs[i].exp_hi);
                chk($sformatf("vec%0d_lo", i), lo_output, vecs[i].exp_lo);
            end
        end

        run_div("div_m7_2", 8'h1A, 32'hFFFF_FFF9, 32'd2, 33,
                32'h0000_0001, 32'h0000_ABCD, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_div("divu_by0", 8'h1B, 32'd5, 32'd0, 1,
                32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF);
        run_div("div_minint", 8'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 33,
                32'd5, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

        // Abort a divide partway through with reset.
        drive(MOV, 8'h11, 32'h0000_0055, 32'd0, 5'd1, 1'b0);
        tick;
        chk("abort_pre_hi", hi_output, 32'h0000_0055);
        drive(MD, 8'h1B, 32'd100, 32'd7, 5'd2, 1'b1);
        #1;
        chk("abort_start_stall", 32'(stall_req), 32'd1);
        repeat (10) tick;
        chk("abort_busy_stall", 32'(stall_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_rst_stall", 32'(stall_req), 32'd0);
        tick;
        rst = 1'b0;
        drive(NOP, 8'h00, 32'd0, 32'd0, 5'd0, 1'b0);
        #1;
        chk("abort_stall", 32'(stall_req), 32'd0);
        chk("abort_hi", hi_output, 32'd0);
        chk("abort_lo", lo_output, 32'd0);
        repeat (40) tick;
        chk("abort_late_hi", hi_output, 32'd0);
        chk("abort_late_lo", lo_output, 32'd0);
        chk("abort_late_stall", 32'(stall_req), 32'd0);

        run_div("divu_100_7", 8'h1B, 32'd100, 32'd7, 33, 32'd0, 32'd0, 32'd2, 32'd14);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
